game_controller: RTL and testbench

- Top-level sequencer for the breakout game.
- Consumes debounced buttons, a per-frame tick and event pulses from the ball and brick logic.
- Drives the enables that decide when the paddle moves, when the ball is held or running, when bricks and score reload, and when scoring is allowed.
- Owns the lives counter and the win/lose outcome.

---
 rtl/breakout_pkg.sv | 18 +
 rtl/game_controller_frame_timer.sv | 15 +
 rtl/game_controller.sv | 85 ++++++++
 tb/tb_game_controller.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// breakout_pkg: state encoding, widths and default game parameters shared by the breakout blocks.
package breakout_pkg;
    localparam int STATE_W          = 3;
    localparam int LIVES_DEF        = 3;
    localparam int SERVE_FRAMES_DEF = 120;
    localparam int HOLD_FRAMES_DEF  = 180;
    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4,
        ST_WIN   = 3'd5
    } state_t;
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/game_controller_frame_timer.sv
// frame_timer: saturating frame_tick counter, cleared synchronously by clear.
module frame_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         tick,
    output logic [W-1:0] count
);
    always_ff @(posedge clk or negedge rst)
        if (!rst) count <= '0;
        else if (clear) count <= '0;
        else if (tick && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/game_controller.sv
// game_controller: breakout sequencer owning lives and win/lose; GAME_AUTO_SERVE_EN enables auto-launch from SERVE.
module game_controller
    import breakout_pkg::*;
#(
    parameter int LIVES        = LIVES_DEF,
    parameter int SERVE_FRAMES = SERVE_FRAMES_DEF,
    parameter int HOLD_FRAMES  = HOLD_FRAMES_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               btn_left,
    input  logic               btn_right,
    input  logic               btn_pause,
    input  logic               brick_hit,
    input  logic               all_cleared,
    input  logic               ball_lost,
    output logic [STATE_W-1:0] state_o,
    output logic               paddle_en,
    output logic               ball_hold,
    output logic               ball_run,
    output logic               field_reload,
    output logic               score_inc,
    output logic [2:0]         lives,
    output logic               game_over,
    output logic               game_won
);
    localparam int CNT_W = $clog2(max_int(SERVE_FRAMES, HOLD_FRAMES) + 1);
    state_t           state, state_nx;
    logic [2:0]       btn_q, btn_edge;
    logic [CNT_W-1:0] cnt;
    logic             press, launch, pause_edge, auto_go, hold_done;
    assign btn_edge   = {btn_pause, btn_right, btn_left} & ~btn_q;
    assign press      = |btn_edge;
    assign launch     = |btn_edge[1:0];
    assign pause_edge = btn_edge[2];
    assign hold_done  = cnt >= CNT_W'(HOLD_FRAMES);
`ifdef GAME_AUTO_SERVE_EN
    assign auto_go    = frame_tick && cnt >= CNT_W'(SERVE_FRAMES);
`else
    assign auto_go    = 1'b0;
`endif
    frame_timer #(.W(CNT_W)) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (state_nx != state),
        .tick  (frame_tick),
        .count (cnt)
    );
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:  state_nx = press ? ST_SERVE : ST_IDLE;
            ST_SERVE: state_nx = (launch || auto_go) ? ST_PLAY : ST_SERVE;
            ST_PLAY:  state_nx = all_cleared ? ST_WIN :
                                 ball_lost   ? (lives <= 3'd1 ? ST_OVER : ST_SERVE) :
                                 pause_edge  ? ST_PAUSE : ST_PLAY;
            ST_PAUSE: state_nx = pause_edge ? ST_PLAY : ST_PAUSE;
            ST_OVER,
            ST_WIN:   state_nx = (press && hold_done) ? ST_IDLE : state;
            default:  state_nx = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state        <= ST_IDLE;
            btn_q        <= '0;
            lives        <= 3'(LIVES);
            field_reload <= 1'b0;
            score_inc    <= 1'b0;
        end else begin
            state        <= state_nx;
            btn_q        <= {btn_pause, btn_right, btn_left};
            field_reload <= state == ST_IDLE && press;
            score_inc    <= state == ST_PLAY && brick_hit;
            if (state == ST_IDLE && press) lives <= 3'(LIVES);
            else if (state == ST_PLAY && !all_cleared && ball_lost && lives != 3'd0) lives <= lives - 3'd1;
        end
    assign state_o   = state;
    assign paddle_en = state == ST_SERVE || state == ST_PLAY;
    assign ball_hold = state == ST_IDLE || state == ST_SERVE;
    assign ball_run  = state == ST_PLAY;
    assign game_over = state == ST_OVER;
    assign game_won  = state == ST_WIN;
endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: directed self-checking bench for game_controller (LIVES=3, SERVE_FRAMES=3, HOLD_FRAMES=4).
module tb_game_controller;
    logic       clk = 1'b0, rst = 1'b0;
    logic       frame_tick = 0, btn_left = 0, btn_right = 0, btn_pause = 0;
    logic       brick_hit = 0, all_cleared = 0, ball_lost = 0;
    logic [2:0] state_o, lives;
    logic       paddle_en, ball_hold, ball_run, field_reload, score_inc, game_over, game_won;
    int         n_checks = 0, n_fail = 0;

    game_controller #(.LIVES(3), .SERVE_FRAMES(3), .HOLD_FRAMES(4)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .btn_left(btn_left), .btn_right(btn_right), .btn_pause(btn_pause),
        .brick_hit(brick_hit), .all_cleared(all_cleared), .ball_lost(ball_lost),
        .state_o(state_o), .paddle_en(paddle_en), .ball_hold(ball_hold), .ball_run(ball_run),
        .field_reload(field_reload), .score_inc(score_inc), .lives(lives),
        .game_over(game_over), .game_won(game_won)
    );

    always #5 clk = ~clk;

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // 0=left 1=right 2=pause; the leading cycle lets the edge detector see a low level first
    task automatic press(input int b);
        cyc;
        btn_left = (b == 0); btn_right = (b == 1); btn_pause = (b == 2);
        cyc;
        btn_left = 0; btn_right = 0; btn_pause = 0;
    endtask

    task automatic ftick(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1;
            cyc;
        end
        frame_tick = 0;
    endtask

    task automatic lose;
        ball_lost = 1;
        cyc;
        ball_lost = 0;
    endtask

    initial begin
        cyc; cyc;
        rst = 1;
        cyc;
        chk("rst_state", state_o, 0);
        chk("rst_lives", lives, 3);
        chk("rst_reload", field_reload, 0);
        chk("rst_score", score_inc, 0);
        chk("idle_hold", ball_hold, 1);
        chk("idle_paddle", paddle_en, 0);

        press(1);
        chk("serve_state", state_o, 1);
        chk("serve_reload", field_reload, 1);
        chk("serve_paddle", paddle_en, 1);
        chk("serve_run", ball_run, 0);
        cyc;
        chk("reload_1cyc", field_reload, 0);
        press(2);
        chk("serve_pause_ign", state_o, 1);
`ifdef GAME_AUTO_SERVE_EN
        ftick(3);
        chk("auto_wait", state_o, 1);
        ftick(1);
        chk("auto_play", state_o, 2);
`else
        ftick(5);
        chk("serve_wait", state_o, 1);
        press(1);
`endif
        chk("play_state", state_o, 2);
        chk("play_run", ball_run, 1);
        chk("play_hold", ball_hold, 0);

        brick_hit = 1;
        #1 chk("score_no_comb", score_inc, 0);
        cyc;
        brick_hit = 0;
        chk("score_lat1", score_inc, 1);
        cyc;
        chk("score_1cyc", score_inc, 0);

        press(2);
        chk("pause_state", state_o, 3);
        chk("pause_paddle", paddle_en, 0);
        chk("pause_hold", ball_hold, 0);
        brick_hit = 1;
        cyc;
        brick_hit = 0;
        chk("pause_score", score_inc, 0);
        lose;
        chk("pause_lost_lives", lives, 3);
        chk("pause_lost_state", state_o, 3);
        press(2);
        chk("unpause", state_o, 2);

        lose;
        chk("lost1_state", state_o, 1);
        chk("lost1_lives", lives, 2);
        press(0);
        chk("relaunch_left", state_o, 2);

        #2 rst = 0;
        #1 chk("arst_state", state_o, 0);
        chk("arst_lives", lives, 3);
        chk("arst_reload", field_reload, 0);
        cyc;
        rst = 1;
        cyc;
        chk("arst_rel_reload", field_reload, 0);
        chk("arst_rel_state", state_o, 0);

        press(1);
        chk("restart_reload", field_reload, 1);
        press(1);
        chk("restart_play", state_o, 2);
        lose;
        chk("lose_a", lives, 2);
        press(1);
        lose;
        chk("lose_b", lives, 1);
        chk("lose_b_state", state_o, 1);
        press(0);
        lose;
        chk("lose_c", lives, 0);
        chk("over_state", state_o, 4);
        chk("over_flag", game_over, 1);
        chk("over_paddle", paddle_en, 0);

        ftick(2);
        press(0);
        chk("over_early", state_o, 4);
        ftick(2);
        press(1);
        chk("over_exit", state_o, 0);
        chk("over_clr", game_over, 0);

        press(1);
        chk("reload_lives", lives, 3);
        press(0);
        ball_lost = 1; all_cleared = 1;
        cyc;
        ball_lost = 0; all_cleared = 0;
        chk("win_state", state_o, 5);
        chk("win_lives", lives, 3);
        chk("win_flag", game_won, 1);
        chk("win_run", ball_run, 0);
        press(2);
        chk("win_early", state_o, 5);
        ftick(4);
        press(2);
        chk("win_exit", state_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
